// File: rtl/spi_slave_adc_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_adc_pkg
// Shared definitions for the SPI ADC slave: FSM state encoding and the
// default command/data lengths used as parameter defaults by the top level.
// -----------------------------------------------------------------------------
package spi_slave_adc_pkg;

    // Frame sequencing states; the encoding is fixed so that other blocks
    // and debug tooling can decode the state register directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int CMD_W_DEF  = 8;
    localparam int DATA_W_DEF = 12;

endpackage : spi_slave_adc_pkg

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk_i domain through a chain of
// STAGES flops and flags rising/falling edges of the synchronized level.
//
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous reset, active-low
//   d_i     raw asynchronous input
//   q_o     synchronized level
//   rise_o  one-cycle pulse on a 0->1 transition of q_o
//   fall_o  one-cycle pulse on a 1->0 transition of q_o
//
// RESET_VAL is the idle level of the pin; every flop, including the edge
// history flop, resets to it so releasing reset never fabricates an edge.
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    assign sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_slave_adc.sv
// -----------------------------------------------------------------------------
// spi_slave_adc
// SPI slave front end for an ADC. The master clocks in a CMD_W-bit command on
// mosi_i and then clocks out a DATA_W-bit conversion word on miso_o, both MSB
// first, in one chip-select frame. All SPI pins are oversampled by clk_i,
// which must run at least 8x the dclk_i frequency.
//
// Ports:
//   clk_i      system clock (single clock domain)
//   rst_i      asynchronous reset, active-low
//   cs_i       chip select from master, active-low
//   dclk_i     SPI clock from master, idle low
//   mosi_i     serial command, MSB first
//   din_i      conversion word, captured when the command completes
//   miso_o     serial response, MSB first, 0 outside the data phase
//   cmd_o      last complete command
//   cmd_vld_o  one-cycle pulse when cmd_o updates
//   eof_o      one-cycle pulse on a complete frame
//   err_o      one-cycle pulse on a frame aborted by cs rising early
//
// Optional feature: define SPI_SLAVE_ADC_ERR_EN to build the abort detector
// behind err_o; otherwise err_o is a constant 0.
// -----------------------------------------------------------------------------
module spi_slave_adc
    import spi_slave_adc_pkg::*;
#(
    parameter int CMD_W       = CMD_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              dclk_i,
    input  logic              mosi_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              miso_o,
    output logic [CMD_W-1:0]  cmd_o,
    output logic              cmd_vld_o,
    output logic              eof_o,
    output logic              err_o
);

    localparam int                CNT_W      = $clog2(CMD_W + DATA_W + 1);
    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(CMD_W + DATA_W - 1);

    logic csLvl, csRise, csFall;
    logic dclkLvl, dclkRise, dclkFall;
    logic mosiSync, mosiRise, mosiFall;
    logic sync_unused;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [CMD_W-1:0]  cmdShift_q, cmdShift_d;
    logic [DATA_W-1:0] dataShift_q, dataShift_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmdVld_q, cmdVld_d;
    logic              eof_q, eof_d;
    logic              miso_q, miso_d;

    // cs idles high, dclk and mosi idle low.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (cs_i),
        .q_o    (csLvl),
        .rise_o (csRise),
        .fall_o (csFall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dclk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (dclk_i),
        .q_o    (dclkLvl),
        .rise_o (dclkRise),
        .fall_o (dclkFall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (mosi_i),
        .q_o    (mosiSync),
        .rise_o (mosiRise),
        .fall_o (mosiFall)
    );

    // Only edges of cs/dclk and the level of mosi are used.
    assign sync_unused = &{csLvl, dclkLvl, mosiRise, mosiFall};

    // Frame sequencing. A cs rising edge is tested before any dclk edge, so
    // a dclk edge seen in the same cycle as the cs release is dropped.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        cmdShift_d  = cmdShift_q;
        dataShift_d = dataShift_q;
        cmd_d       = cmd_q;
        cmdVld_d    = 1'b0;
        eof_d       = 1'b0;
        miso_d      = miso_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (csFall) begin
                    state_d  = CMD;
                    bitCnt_d = '0;
                end
            end

            CMD: begin
                miso_d = 1'b0;
                if (csRise) begin
                    state_d = IDLE;
                end else if (dclkRise) begin
                    cmdShift_d = {cmdShift_q[CMD_W-2:0], mosiSync};
                    bitCnt_d   = bitCnt_q + CNT_W'(1);
                    if (bitCnt_q == CMD_LAST) begin
                        cmd_d       = {cmdShift_q[CMD_W-2:0], mosiSync};
                        cmdVld_d    = 1'b1;
                        dataShift_d = din_i;
                        state_d     = DATA;
                    end
                end
            end

            DATA: begin
                if (csRise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else if (dclkRise) begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                    if (bitCnt_q == FRAME_LAST) begin
                        state_d = DONE;
                        eof_d   = 1'b1;
                        miso_d  = 1'b0;
                    end
                end else if (dclkFall) begin
                    // Present the next bit half a dclk period ahead of the
                    // master's sampling edge.
                    miso_d      = dataShift_q[DATA_W-1];
                    dataShift_d = {dataShift_q[DATA_W-2:0], 1'b0};
                end
            end

            DONE: begin
                miso_d = 1'b0;
                if (csRise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            cmdShift_q  <= '0;
            dataShift_q <= '0;
            cmd_q       <= '0;
            cmdVld_q    <= 1'b0;
            eof_q       <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            cmdShift_q  <= cmdShift_d;
            dataShift_q <= dataShift_d;
            cmd_q       <= cmd_d;
            cmdVld_q    <= cmdVld_d;
            eof_q       <= eof_d;
            miso_q      <= miso_d;
        end
    end

`ifdef SPI_SLAVE_ADC_ERR_EN
    logic err_q, err_d;

    // An early cs release while the frame is still being shifted.
    always_comb begin
        err_d = 1'b0;
        if (csRise && (state_q == CMD || state_q == DATA)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign miso_o    = miso_q;
    assign cmd_o     = cmd_q;
    assign cmd_vld_o = cmdVld_q;
    assign eof_o     = eof_q;

endmodule : spi_slave_adc

// File: tb/tb_spi_slave_adc.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_adc
// Self-checking bench for spi_slave_adc with default parameters. A behavioural
// SPI master drives frames at a 10:1 clk_i:dclk_i ratio. Expected commands and
// data words are queued as frames are driven; observed commands (captured on
// cmd_vld_o) and words read back by the master are compared against them.
// Define SPI_SLAVE_ADC_ERR_EN for both bench and RTL to test the err_o path.
// -----------------------------------------------------------------------------
module tb_spi_slave_adc;

    localparam int CMD_W  = 8;
    localparam int DATA_W = 12;
    localparam int FRAME  = CMD_W + DATA_W;
    localparam int HALF   = 5;

`ifdef SPI_SLAVE_ADC_ERR_EN
    localparam int EXP_ABORT_ERR = 1;
`else
    localparam int EXP_ABORT_ERR = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              cs;
    logic              dclk;
    logic              mosi;
    logic [DATA_W-1:0] din;
    logic              miso;
    logic [CMD_W-1:0]  cmdOut;
    logic              cmdVld;
    logic              eof;
    logic              err;

    int checks = 0;
    int errors = 0;

    int cmdVldCnt = 0;
    int eofCnt    = 0;
    int errCnt    = 0;

    logic [CMD_W-1:0]  expCmdQ[$];
    logic [DATA_W-1:0] expDataQ[$];
    logic [CMD_W-1:0]  gotCmdQ[$];

    logic [CMD_W-1:0]  lastCmd;
    logic [DATA_W-1:0] readWord;
    bit                extraBad;
    bit                changeDin;
    logic [DATA_W-1:0] newDin;

    spi_slave_adc dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .cs_i      (cs),
        .dclk_i    (dclk),
        .mosi_i    (mosi),
        .din_i     (din),
        .miso_o    (miso),
        .cmd_o     (cmdOut),
        .cmd_vld_o (cmdVld),
        .eof_o     (eof),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (cmdVld) begin
            cmdVldCnt <= cmdVldCnt + 1;
            gotCmdQ.push_back(cmdOut);
        end
        if (eof) eofCnt <= eofCnt + 1;
        if (err) errCnt <= errCnt + 1;
    end

    task automatic csLow();
        @(negedge clk);
        cs = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic csHigh();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Drive dclk pulses first..first+count-1 of a frame (0-based). The master
    // samples miso just before each rising edge; after the last frame bit any
    // high miso is flagged. Optionally swaps din one cycle after cmd_vld_o.
    task automatic pulses(input logic [CMD_W-1:0] cmd, input int first, input int count);
        bit pending;
        pending = 1'b0;
        for (int b = first; b < first + count; b++) begin
            mosi = (b < CMD_W) ? cmd[CMD_W-1-b] : 1'b0;
            for (int t = 0; t < HALF; t++) begin
                @(negedge clk);
                if (b >= FRAME && miso !== 1'b0) extraBad = 1'b1;
            end
            if (b >= CMD_W && b < FRAME) readWord[FRAME-1-b] = miso;
            dclk = 1'b1;
            for (int t = 0; t < HALF; t++) begin
                @(negedge clk);
                if (pending) begin
                    din = newDin;
                    pending = 1'b0;
                end
                if (changeDin && cmdVld) begin
                    pending = 1'b1;
                    changeDin = 1'b0;
                end
                if (b >= FRAME && miso !== 1'b0) extraBad = 1'b1;
            end
            dclk = 1'b0;
        end
    endtask

    task automatic fullFrame(input logic [CMD_W-1:0] cmd, input logic [DATA_W-1:0] word,
                             input int nPulses);
        din = word;
        expCmdQ.push_back(cmd);
        expDataQ.push_back(word);
        readWord = '0;
        extraBad = 1'b0;
        csLow();
        pulses(cmd, 0, nPulses);
        csHigh();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs    = 1'b1;
        dclk  = 1'b0;
        mosi  = 1'b0;
        din   = '0;
        changeDin = 1'b0;
        newDin = '0;
        lastCmd = '0;
        repeat (3) @(negedge clk);
        checks++; if (miso !== 1'b0)   begin errors++; $display("[TB] FAIL reset_miso got=%b exp=0", miso); end
        checks++; if (cmdOut !== '0)   begin errors++; $display("[TB] FAIL reset_cmd got=%h exp=00", cmdOut); end
        checks++; if (cmdVld !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_vld got=%b exp=0", cmdVld); end
        checks++; if (eof !== 1'b0)    begin errors++; $display("[TB] FAIL reset_eof got=%b exp=0", eof); end
        checks++; if (err !== 1'b0)    begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (cmdVldCnt + eofCnt + errCnt != 0) begin
            errors++; $display("[TB] FAIL reset_release_pulses got=%0d exp=0", cmdVldCnt + eofCnt + errCnt);
        end
    endtask

    // Pop one expected/observed command pair and one expected/read data pair.
    task automatic test_frame(input string name, input logic [CMD_W-1:0] cmd,
                              input logic [DATA_W-1:0] word);
        int v0, e0, r0;
        logic [CMD_W-1:0]  ec, gc;
        logic [DATA_W-1:0] ed;
        v0 = cmdVldCnt; e0 = eofCnt; r0 = errCnt;
        fullFrame(cmd, word, FRAME);
        lastCmd = cmd;
        ec = expCmdQ.pop_front();
        ed = expDataQ.pop_front();
        checks++;
        if (gotCmdQ.size() == 0) begin
            errors++; $display("[TB] FAIL %s_cmd got=none exp=%h", name, ec);
        end else begin
            gc = gotCmdQ.pop_front();
            if (gc !== ec) begin errors++; $display("[TB] FAIL %s_cmd got=%h exp=%h", name, gc, ec); end
        end
        checks++; if (readWord !== ed) begin errors++; $display("[TB] FAIL %s_data got=%h exp=%h", name, readWord, ed); end
        checks++; if (cmdVldCnt - v0 != 1) begin errors++; $display("[TB] FAIL %s_cmd_vld got=%0d exp=1", name, cmdVldCnt - v0); end
        checks++; if (eofCnt - e0 != 1) begin errors++; $display("[TB] FAIL %s_eof got=%0d exp=1", name, eofCnt - e0); end
        checks++; if (errCnt - r0 != 0) begin errors++; $display("[TB] FAIL %s_err got=%0d exp=0", name, errCnt - r0); end
    endtask

    task automatic test_basic();
        test_frame("basic", 8'hA5, 12'hABC);
    endtask

    task automatic test_back_to_back();
        test_frame("b2b_first", 8'h01, 12'h000);
        test_frame("b2b_second", 8'hFF, 12'hFFF);
    endtask

    task automatic test_abort();
        int v0, e0, r0;
        v0 = cmdVldCnt; e0 = eofCnt; r0 = errCnt;
        din = 12'h3F0;
        csLow();
        pulses(8'h5A, 0, 5);
        csHigh();
        checks++; if (cmdOut !== lastCmd) begin errors++; $display("[TB] FAIL abort_cmd got=%h exp=%h", cmdOut, lastCmd); end
        checks++; if (cmdVldCnt - v0 != 0) begin errors++; $display("[TB] FAIL abort_cmd_vld got=%0d exp=0", cmdVldCnt - v0); end
        checks++; if (eofCnt - e0 != 0) begin errors++; $display("[TB] FAIL abort_eof got=%0d exp=0", eofCnt - e0); end
        checks++; if (errCnt - r0 != EXP_ABORT_ERR) begin
            errors++; $display("[TB] FAIL abort_err got=%0d exp=%0d", errCnt - r0, EXP_ABORT_ERR);
        end
        checks++; if (miso !== 1'b0) begin errors++; $display("[TB] FAIL abort_miso got=%b exp=0", miso); end
    endtask

    task automatic test_mid_reset();
        int e0;
        logic [CMD_W-1:0] ec, gc;
        e0 = eofCnt;
        din = 12'hEEE;
        expCmdQ.push_back(8'h77);
        csLow();
        pulses(8'h77, 0, 12);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (miso !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_miso got=%b exp=0", miso); end
        checks++; if (cmdOut !== '0)   begin errors++; $display("[TB] FAIL midrst_cmd got=%h exp=00", cmdOut); end
        checks++; if (cmdVld !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cmd_vld got=%b exp=0", cmdVld); end
        checks++; if (eof !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_eof got=%b exp=0", eof); end
        checks++; if (err !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_err got=%b exp=0", err); end
        ec = expCmdQ.pop_front();
        checks++;
        if (gotCmdQ.size() == 0) begin
            errors++; $display("[TB] FAIL midrst_partial_cmd got=none exp=%h", ec);
        end else begin
            gc = gotCmdQ.pop_front();
            if (gc !== ec) begin errors++; $display("[TB] FAIL midrst_partial_cmd got=%h exp=%h", gc, ec); end
        end
        cs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (eofCnt - e0 != 0) begin errors++; $display("[TB] FAIL midrst_eof_cnt got=%0d exp=0", eofCnt - e0); end
        test_frame("after_reset", 8'h3C, 12'h5A5);
    endtask

    task automatic test_din_change();
        newDin = 12'h456;
        changeDin = 1'b1;
        test_frame("din_change", 8'hC3, 12'h123);
        checks++; if (din !== 12'h456) begin errors++; $display("[TB] FAIL din_change_applied got=%h exp=456", din); end
    endtask

    task automatic test_extra_edges();
        int e0;
        logic [CMD_W-1:0]  ec, gc;
        logic [DATA_W-1:0] ed;
        e0 = eofCnt;
        fullFrame(8'h96, 12'h9E1, FRAME + 3);
        ec = expCmdQ.pop_front();
        ed = expDataQ.pop_front();
        checks++;
        if (gotCmdQ.size() == 0) begin
            errors++; $display("[TB] FAIL extra_cmd got=none exp=%h", ec);
        end else begin
            gc = gotCmdQ.pop_front();
            if (gc !== ec) begin errors++; $display("[TB] FAIL extra_cmd got=%h exp=%h", gc, ec); end
        end
        checks++; if (readWord !== ed) begin errors++; $display("[TB] FAIL extra_data got=%h exp=%h", readWord, ed); end
        checks++; if (extraBad !== 1'b0) begin errors++; $display("[TB] FAIL extra_miso got=%b exp=0", extraBad); end
        checks++; if (eofCnt - e0 != 1) begin errors++; $display("[TB] FAIL extra_eof got=%0d exp=1", eofCnt - e0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        test_din_change();
        test_extra_edges();
        checks++;
        if (gotCmdQ.size() != 0) begin
            errors++; $display("[TB] FAIL leftover_cmds got=%0d exp=0", gotCmdQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spi_slave_adc

// File: doc/spi_slave_adc.md
SPI_SLAVE_ADC -- requirements
Module: spi_slave_adc

Interface
REQ-001 Parameter CMD_W, default 8, command length in bits.
REQ-002 Parameter DATA_W, default 12, response data length in bits.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth on cs_i, dclk_i, mosi_i.
REQ-004 clk_i  input  1  system clock; one clock domain only.
REQ-005 rst_i  input  1  asynchronous reset, active-low.
REQ-006 cs_i  input  1  chip select from master, active-low.
REQ-007 dclk_i  input  1  SPI clock from master; idle low.
REQ-008 mosi_i  input  1  serial command from master, MSB first.
REQ-009 din_i  input  DATA_W  conversion word returned to master.
REQ-010 miso_o  output  1  serial response, MSB first.
REQ-011 cmd_o  output  CMD_W  last complete command byte.
REQ-012 cmd_vld_o  output  1  one-cycle pulse when cmd_o updates.
REQ-013 eof_o  output  1  one-cycle pulse on complete frame.
REQ-014 err_o  output  1  one-cycle pulse on aborted frame (see Configuration).

Function
REQ-015 The block SHALL synchronize cs_i, dclk_i and mosi_i through SYNC_STAGES flops and detect dclk rise/fall edges and cs fall/rise edges on the synchronized signals.
REQ-016 clk_i SHALL be at least 8x the dclk_i frequency; slower ratios are unsupported.
REQ-017 FSM states SHALL be IDLE, CMD, DATA, DONE.
REQ-018 IDLE->CMD on synchronized cs falling edge; the bit counter clears to 0.
REQ-019 In CMD, each dclk rising edge SHALL shift the synchronized mosi into the command shift register (MSB first) and increment the bit counter.
REQ-020 On the CMD_W-th rising edge: cmd_o loads the shift register, cmd_vld_o pulses for one cycle, din_i is captured into the data shift register in that same cycle, and the FSM goes to DATA.
REQ-021 In DATA, each dclk falling edge SHALL drive the next data bit onto miso_o, MSB (bit DATA_W-1) first, so the master samples it on the following rising edge.
REQ-022 On the (CMD_W+DATA_W)-th rising edge (20 with defaults) the FSM SHALL enter DONE, pulse eof_o for one cycle and hold miso_o at 0.
REQ-023 DONE->IDLE on the synchronized cs rising edge; further dclk edges in DONE are ignored.
REQ-024 A cs rising edge in CMD or DATA SHALL return the FSM to IDLE without updating cmd_o and without pulsing eof_o.
REQ-025 miso_o SHALL be 0 in IDLE, CMD and DONE.
REQ-026 A cs rising edge and a dclk edge detected in the same cycle SHALL resolve as cs first; that dclk edge is discarded.
REQ-027 din_i changes outside the capture cycle SHALL have no effect on the frame in progress.

Reset
REQ-028 While rst_i=0, all flops SHALL clear asynchronously: FSM=IDLE, counters=0, and miso_o, cmd_o, cmd_vld_o, eof_o, err_o all 0.
REQ-029 Synchronizer flops SHALL reset to cs=1, dclk=0, mosi=0, so release of reset cannot create a false edge.
REQ-030 Reset asserted mid-frame SHALL abort the frame silently; the next frame requires a fresh cs falling edge.

Configuration
REQ-031 With SPI_SLAVE_ADC_ERR_EN defined, a cs rising edge in CMD or DATA SHALL pulse err_o for one cycle.
REQ-032 Without SPI_SLAVE_ADC_ERR_EN, err_o SHALL be tied to 0 and no error logic is synthesized; all other behaviour is identical.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, CMD=2'd1, DATA=2'd2, DONE=2'd3) and the default CMD_W and DATA_W constants.
REQ-034 The synchronizer plus edge detector SHALL be a sub-module named spi_sync_edge, instantiated once per synchronized input.

Verification
REQ-035 Frame with cmd 8'hA5, din_i=12'hABC, clk_i:dclk_i ratio 10:1 -> cmd_o=8'hA5 with cmd_vld_o pulse; master reads 12'hABC; exactly one eof_o pulse.
REQ-036 Two back-to-back frames (cmd 8'h01/din_i 12'h000, then cmd 8'hFF/din_i 12'hFFF) -> both commands reported and both words read back correctly; no err_o.
REQ-037 cs raised after 5 dclk edges -> cmd_o unchanged, no cmd_vld_o, no eof_o; err_o pulses once only if SPI_SLAVE_ADC_ERR_EN is defined.
REQ-038 rst_i pulled low after the 12th dclk edge, then released -> all outputs 0; next full frame with cmd 8'h3C/din_i 12'h5A5 completes correctly.
REQ-039 din_i changed from 12'h123 to 12'h456 one cycle after the cmd_vld_o pulse -> master reads 12'h123.
REQ-040 Extra dclk edges after the 20th edge with cs still low -> miso_o stays 0; no second eof_o pulse.
